// File: rtl/pmem_line_pkg.sv
// Shared definitions for the physical-memory line responder.
// Provides default line/beat geometry, the controller state type and the
// line/beat data types used by pmem_line_responder and line_beat_buffer.
package pmem_line_pkg;

    localparam int unsigned LINE_W      = 256;
    localparam int unsigned BURST_W     = 64;
    localparam int unsigned BEATS       = LINE_W / BURST_W;
    localparam int unsigned OFFSET_BITS = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } pmem_state_t;

    typedef logic [LINE_W-1:0]  line_t;
    typedef logic [BURST_W-1:0] beat_t;

endpackage

// File: rtl/line_beat_buffer.sv
// Line buffer and beat counter for the line responder.
// Holds one cache line and a beat index. The line is either loaded whole
// (write data) or assembled one beat at a time (read data).
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   load_line      - load line_in into the buffer
//   line_in        - full line to load
//   capture_beat   - write beat_in into the slot selected by the counter
//   beat_in        - incoming read beat
//   advance        - increment the beat counter
//   clear          - reset the beat counter to 0
//   line_merged    - buffer contents with beat_in inserted at the current slot
//   beat_out       - buffer slice selected by the current beat index
//   last_beat      - counter is at the final beat of the line
module line_beat_buffer
    import pmem_line_pkg::*;
#(
    parameter int unsigned LINE_W  = pmem_line_pkg::LINE_W,
    parameter int unsigned BURST_W = pmem_line_pkg::BURST_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_line,
    input  logic [LINE_W-1:0]  line_in,
    input  logic               capture_beat,
    input  logic [BURST_W-1:0] beat_in,
    input  logic               advance,
    input  logic               clear,
    output logic [LINE_W-1:0]  line_merged,
    output logic [BURST_W-1:0] beat_out,
    output logic               last_beat
);

    localparam int unsigned NBEATS = LINE_W / BURST_W;
    localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    logic [LINE_W-1:0] line_q, line_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        line_merged = line_q;
        line_merged[BURST_W*cnt_q +: BURST_W] = beat_in;
    end

    assign beat_out  = line_q[BURST_W*cnt_q +: BURST_W];
    assign last_beat = (cnt_q == CNT_W'(NBEATS - 1));

    always_comb begin
        line_d = line_q;
        cnt_d  = cnt_q;
        if (load_line) begin
            line_d = line_in;
        end else if (capture_beat) begin
            line_d = line_merged;
        end
        if (clear) begin
            cnt_d = '0;
        end else if (advance) begin
            // Wraps to 0 after the last beat, ready for the next line.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
            cnt_q  <= '0;
        end else begin
            line_q <= line_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/pmem_line_responder.sv
// Responder for the L2 cache physical-memory line interface.
// Accepts one line request (read or write) at a time and serves it as a
// BEATS-long burst on the memory side, then pulses pmem_resp for one cycle.
// Optional build macro PMEM_EARLY_RESP_EN: drops the DONE state, asserts
// pmem_resp combinationally with the final beat and bypasses the last read
// beat onto pmem_rdata in that cycle.
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   pmem_read, pmem_write      - line request, held until pmem_resp
//   pmem_address, pmem_wdata   - line address (offset ignored) and write data
//   pmem_rdata, pmem_resp      - registered read line, completion pulse
//   burst_read, burst_write    - memory burst request, high for whole burst
//   burst_address              - line-aligned burst address
//   burst_wdata, burst_rdata   - current write / read beat
//   burst_resp                 - memory moved one beat this cycle
module pmem_line_responder
    import pmem_line_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = pmem_line_pkg::LINE_W,
    parameter int unsigned BURST_W = pmem_line_pkg::BURST_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pmem_read,
    input  logic               pmem_write,
    input  logic [ADDR_W-1:0]  pmem_address,
    input  logic [LINE_W-1:0]  pmem_wdata,
    output logic [LINE_W-1:0]  pmem_rdata,
    output logic               pmem_resp,
    output logic               burst_read,
    output logic               burst_write,
    output logic [ADDR_W-1:0]  burst_address,
    output logic [BURST_W-1:0] burst_wdata,
    input  logic [BURST_W-1:0] burst_rdata,
    input  logic               burst_resp
);

    localparam int unsigned OFF_BITS = $clog2(LINE_W / 8);

    pmem_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;

    logic               load_line;
    logic               capture_beat;
    logic               advance;
    logic               clear;
    logic [LINE_W-1:0]  line_merged;
    logic [BURST_W-1:0] beat_out;
    logic               last_beat;

    line_beat_buffer #(
        .LINE_W  (LINE_W),
        .BURST_W (BURST_W)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .load_line    (load_line),
        .line_in      (pmem_wdata),
        .capture_beat (capture_beat),
        .beat_in      (burst_rdata),
        .advance      (advance),
        .clear        (clear),
        .line_merged  (line_merged),
        .beat_out     (beat_out),
        .last_beat    (last_beat)
    );

    assign burst_address = addr_q;

`ifdef PMEM_EARLY_RESP_EN
    // Final read beat goes straight through so the line is whole in the
    // response cycle.
    assign pmem_rdata = (state_q == RD_BURST && burst_resp && last_beat) ? line_merged
                                                                         : rdata_q;
`else
    assign pmem_rdata = rdata_q;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
        load_line    = 1'b0;
        capture_beat = 1'b0;
        advance      = 1'b0;
        clear        = 1'b0;
        burst_read   = 1'b0;
        burst_write  = 1'b0;
        burst_wdata  = '0;
        pmem_resp    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pmem_read || pmem_write) begin
                    addr_d                 = pmem_address;
                    addr_d[OFF_BITS-1:0]   = '0;
                    load_line              = 1'b1;
                    clear                  = 1'b1;
                    // Write wins if both are asserted.
                    state_d = pmem_write ? WR_BURST : RD_BURST;
                end
            end
            RD_BURST: begin
                burst_read = 1'b1;
                if (burst_resp) begin
                    capture_beat = 1'b1;
                    advance      = 1'b1;
                    if (last_beat) begin
                        // pmem_rdata only changes once the whole line is in.
                        rdata_d = line_merged;
`ifdef PMEM_EARLY_RESP_EN
                        pmem_resp = 1'b1;
                        state_d   = IDLE;
`else
                        state_d   = DONE;
`endif
                    end
                end
            end
            WR_BURST: begin
                burst_write = 1'b1;
                burst_wdata = beat_out;
                if (burst_resp) begin
                    advance = 1'b1;
                    if (last_beat) begin
`ifdef PMEM_EARLY_RESP_EN
                        pmem_resp = 1'b1;
                        state_d   = IDLE;
`else
                        state_d   = DONE;
`endif
                    end
                end
            end
            DONE: begin
                pmem_resp = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_pmem_line_responder.sv
// Scoreboard bench for pmem_line_responder: directed scenarios followed by
// randomized line traffic against a behavioural memory and line model.
module tb_pmem_line_responder;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned LINE_W  = 256;
    localparam int unsigned BURST_W = 64;
    localparam int unsigned BEATS   = 4;
`ifdef PMEM_EARLY_RESP_EN
    localparam int unsigned RESP_EXTRA = 0;
`else
    localparam int unsigned RESP_EXTRA = 1;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               pmem_read;
    logic               pmem_write;
    logic [ADDR_W-1:0]  pmem_address;
    logic [LINE_W-1:0]  pmem_wdata;
    logic [LINE_W-1:0]  pmem_rdata;
    logic               pmem_resp;
    logic               burst_read;
    logic               burst_write;
    logic [ADDR_W-1:0]  burst_address;
    logic [BURST_W-1:0] burst_wdata;
    logic [BURST_W-1:0] burst_rdata;
    logic               burst_resp;

    pmem_line_responder dut (
        .clk           (clk),
        .rst           (rst),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_address (burst_address),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit           is_wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        int unsigned  start;
    } txn_t;

    txn_t txn_q[$];

    // Reference state: last fully read line, and the line being gathered.
    logic [255:0] model_line = '0;
    logic [255:0] pend_line  = '0;

    // Memory behaviour knobs.
    int stall_pct     = 0;
    int stall_at_beat = -1;
    int stall_len     = 0;
    bit stall_used    = 1'b0;
    int stall_left    = 0;
    bit fixed_pattern = 1'b0;
    int mem_beat      = 0;

    int mon_beat   = 0;
    int mon_stalls = 0;

    task automatic check_val(input string name, input logic [255:0] act,
                             input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: drives burst_resp/burst_rdata just after each rising edge.
    initial begin
        logic [7:0] b;
        burst_resp  = 1'b0;
        burst_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            burst_resp = 1'b0;
            if (rst) begin
                mem_beat   = 0;
                stall_left = 0;
            end else if (burst_read || burst_write) begin
                if (stall_left > 0) begin
                    stall_left--;
                end else if (mem_beat == stall_at_beat && !stall_used) begin
                    stall_used = 1'b1;
                    stall_left = stall_len - 1;
                end else if (int'($urandom_range(99)) < stall_pct) begin
                    burst_resp = 1'b0;
                end else begin
                    burst_resp = 1'b1;
                    if (burst_read) begin
                        if (fixed_pattern) begin
                            b = 8'((mem_beat + 1) * 17);
                            burst_rdata = {8{b}};
                        end else begin
                            burst_rdata = {$urandom, $urandom};
                        end
                        pend_line[64*mem_beat +: 64] = burst_rdata;
                        if (mem_beat == BEATS - 1) model_line = pend_line;
                    end
                    mem_beat = (mem_beat + 1) % BEATS;
                end
            end
        end
    end

    // Monitor: checks every beat and every response against the scoreboard.
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_beat   = 0;
                mon_stalls = 0;
            end else begin
                if (burst_read || burst_write) begin
                    if (txn_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL burst_idle: got rd=%0b wr=%0b expected no burst",
                                 burst_read, burst_write);
                    end else begin
                        t = txn_q[0];
                        check_val("burst_dir", 256'({burst_write, burst_read}),
                                  t.is_wr ? 256'(2'b10) : 256'(2'b01));
                        check_val("burst_addr", 256'(burst_address), 256'(t.addr));
                        if (burst_resp) begin
                            if (t.is_wr)
                                check_val("burst_wdata", 256'(burst_wdata),
                                          256'(t.wdata[64*mon_beat +: 64]));
                            mon_beat++;
                        end else begin
                            mon_stalls++;
                        end
                    end
                end
                if (pmem_resp) begin
                    if (txn_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL resp_unexpected: got pmem_resp=1 expected 0");
                    end else begin
                        t = txn_q.pop_front();
                        check_val("beat_count", 256'(mon_beat), 256'(BEATS));
                        check_val("pmem_rdata", pmem_rdata, model_line);
                        check_val("latency", 256'(cyc - t.start),
                                  256'(BEATS + RESP_EXTRA + mon_stalls));
                    end
                    mon_beat   = 0;
                    mon_stalls = 0;
                end
            end
        end
    end

    // Called just after a rising edge.
    task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wd);
        txn_t t;
        t.is_wr = wr;
        t.addr  = addr & 32'hFFFF_FFE0;
        t.wdata = wd;
        t.start = cyc;
        txn_q.push_back(t);
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wd;
    endtask

    // Waits for pmem_resp, scrambling address/data mid-burst, then drops the
    // request on the edge that observes the response.
    task automatic wait_resp();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                pmem_address = $urandom;
                pmem_wdata   = {8{$urandom}};
            end
        end while (!pmem_resp && n < 300);
        if (!pmem_resp) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got no pmem_resp expected one within 300 cycles");
        end
        @(posedge clk);
        #1;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
    endtask

    initial begin
        logic [255:0] t1_line;
        logic [255:0] wd;
        int           k;
        int           g;
        int           n;

        t1_line = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        rst          = 1'b1;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;

        repeat (3) @(posedge clk);
        #2;
        check_val("rst_resp",   256'(pmem_resp),     256'(0));
        check_val("rst_bread",  256'(burst_read),    256'(0));
        check_val("rst_bwrite", 256'(burst_write),   256'(0));
        check_val("rst_baddr",  256'(burst_address), 256'(0));
        check_val("rst_bwdata", 256'(burst_wdata),   256'(0));
        check_val("rst_rdata",  pmem_rdata,          256'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Read with fixed beat pattern, no stalls.
        fixed_pattern = 1'b1;
        issue(1'b1, 1'b0, 32'h0000_1234, {8{$urandom}});
        wait_resp();
        check_val("t1_rdata", pmem_rdata, t1_line);
        fixed_pattern = 1'b0;

        // Line write; read data must hold.
        wd = {8{32'hDEAD_BEEF}};
        wd[255:192] = 64'hDEAD_0003_0003_BEEF;
        wd[63:0]    = 64'hDEAD_0000_0000_BEEF;
        issue(1'b0, 1'b1, 32'h0000_0040, wd);
        wait_resp();
        check_val("t2_rdata_kept", pmem_rdata, t1_line);

        // Read with a 3-cycle stall before beat 2.
        stall_at_beat = 2;
        stall_len     = 3;
        stall_used    = 1'b0;
        issue(1'b1, 1'b0, 32'h0000_2F00, '0);
        wait_resp();
        stall_at_beat = -1;

        // Write-back immediately followed by a read.
        issue(1'b0, 1'b1, 32'h0001_0000, {8{$urandom}});
        wait_resp();
        issue(1'b1, 1'b0, 32'h0002_0020, '0);
        wait_resp();

        // Both request lines high: write is taken.
        issue(1'b1, 1'b1, 32'h0003_0060, {8{$urandom}});
        wait_resp();

        // Reset in the middle of a write burst.
        issue(1'b0, 1'b1, 32'h0004_0000, {8{$urandom}});
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (mon_beat < 2 && n < 100);
        check_val("t4_reached_beat2", 256'(mon_beat >= 2), 256'(1));
        rst = 1'b1;
        #1;
        check_val("t4_bwrite_rst", 256'(burst_write), 256'(0));
        check_val("t4_resp_rst",   256'(pmem_resp),   256'(0));
        txn_q.delete();
        model_line = '0;
        pmem_write = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(1'b1, 1'b0, 32'h0005_0080, '0);
        wait_resp();

        // Randomized traffic with random stalls and idle gaps.
        stall_pct = 25;
        for (int i = 0; i < 40; i++) begin
            k = int'($urandom_range(2));
            issue(k != 1, k != 0, $urandom, {8{$urandom}});
            wait_resp();
            g = int'($urandom_range(2));
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
        end

        repeat (5) @(posedge clk);
        check_val("txn_drain", 256'(txn_q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmem_line_responder.md
Name: pmem_line_responder

Overview:
Responder side of the L2 cache's physical-memory line interface, driven by the pmem_read, pmem_write, pmem_address and pmem_resp signals. It accepts one 256-bit cache-line request at a time and serves it as a 4-beat, 64-bit burst on the memory-side burst interface. It assembles read beats into a line, or splits a write line into beats, then returns a single-cycle pmem_resp. It sits between cache_l2 and main memory.

Parameters:
- ADDR_W, 32, byte-address width of pmem_address and burst_address.
- LINE_W, 256, cache-line width in bits.
- BURST_W, 64, width of one burst beat.
- BEATS (localparam, not overridable), LINE_W/BURST_W = 4, beats per line. The beat counter is clog2(BEATS) bits wide.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst, input, 1, asynchronous active-high reset.
- pmem_read, input, 1, line-read request; held high until pmem_resp.
- pmem_write, input, 1, line-write request; held high until pmem_resp.
- pmem_address, input, ADDR_W, line address; low log2(LINE_W/8) bits ignored.
- pmem_wdata, input, LINE_W, write line data.
- pmem_rdata, output, LINE_W, read line data.
- pmem_resp, output, 1, one-cycle completion pulse.
- burst_read, output, 1, memory burst read request.
- burst_write, output, 1, memory burst write request.
- burst_address, output, ADDR_W, line-aligned burst address.
- burst_wdata, output, BURST_W, current write beat.
- burst_rdata, input, BURST_W, current read beat.
- burst_resp, input, 1, memory accepted or produced one beat this cycle.

Behaviour:
- Reset (async, any state): state=IDLE, beat counter=0.
  - pmem_resp, burst_read and burst_write are 0.
  - burst_address, burst_wdata, pmem_rdata and the latched line are 0.
  - Reset mid-burst abandons the burst with no pmem_resp; the memory must tolerate the dropped request.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - Sample on posedge when pmem_read|pmem_write.
  - Latch the address with low 5 bits forced to 0, latch pmem_wdata, clear the counter.
  - Write-only -> WR_BURST; read-only -> RD_BURST.
  - Both asserted: write wins -> WR_BURST (protocol error; the cache never does this).
- RD_BURST:
  - burst_read=1, burst_address = latched address.
  - On each burst_resp, capture burst_rdata into rdata[BURST_W*cnt +: BURST_W] and increment cnt.
  - burst_resp with cnt==BEATS-1 -> DONE.
- WR_BURST:
  - burst_write=1, burst_wdata = latched line[BURST_W*cnt +: BURST_W].
  - Increment cnt on burst_resp; burst_resp with cnt==BEATS-1 -> DONE.
- Burst stalls: burst_resp low holds the state, counter and beat data indefinitely.
- burst_read/burst_write stay high for the whole burst and drop in the cycle after the final beat.
- DONE: pmem_resp=1 for exactly one cycle, then -> IDLE.
  - The requester must deassert its request on the edge that observes pmem_resp.
  - A request sampled in IDLE after that edge starts a new transaction (back-to-back write-back then read is legal).
- pmem_rdata is registered and valid from pmem_resp onward. It holds until the final beat of the next read and is unchanged by writes.
- Request inputs and the address are not re-sampled outside IDLE; changes mid-burst are ignored.
- Latency with burst_resp every cycle:
  - Request sampled at edge 0; beats at edges 1-4; pmem_resp high in the cycle after edge 4.
  - That is 5 cycles to response, 6 cycles request-to-request.

Optional Feature:
- Macro: PMEM_EARLY_RESP_EN.
- Defined:
  - The DONE state is removed.
  - pmem_resp is asserted combinationally in the cycle of the final beat's burst_resp; next state is IDLE.
  - For reads, pmem_rdata bypasses the last beat combinationally from burst_rdata, so the full line is valid in that cycle.
  - Latency is one cycle shorter.
- Undefined: registered DONE behaviour as above.

Decomposition:
- Package pmem_line_pkg:
  - LINE_W, BURST_W, BEATS, OFFSET_BITS.
  - typedef pmem_state_t enum {IDLE, RD_BURST, WR_BURST, DONE}.
  - typedefs line_t and beat_t.
- Sub-module line_beat_buffer:
  - Contains the LINE_W register, the beat counter, beat insert (read) and beat select (write).
  - Controlled by load_line, capture_beat, advance and clear.
  - The FSM stays in the top module.

Test Plan:
1. Read 0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with burst_resp every cycle -> burst_address=0x0000_1220; pmem_rdata={0x44..,0x33..,0x22..,0x11..}; pmem_resp one cycle, 5 cycles after sampling.
2. Write line 0xDEAD...BEEF to 0x0000_0040 -> burst_write held 4 beats; beat0 = line[63:0], beat3 = line[255:192]; single pmem_resp; pmem_rdata unchanged.
3. Read with burst_resp low for 3 cycles before beat 2 -> counter and state hold; correct line assembled; pmem_resp delayed by 3 cycles.
4. Assert rst after beat 1 of a write -> same cycle: burst_write=0, state IDLE, pmem_resp never pulses; a new read then completes normally.
5. Write-back then immediate read (eviction pattern): pmem_write until resp, then pmem_read next cycle -> two complete bursts, two pmem_resp pulses, no lost beats.
6. pmem_read and pmem_write both high -> WR_BURST taken; under PMEM_EARLY_RESP_EN, pmem_resp coincides with the final burst_resp and latency is 4 cycles.
